// File: rtl/block_lock_ctrl.sv
// rtl/block_lock_ctrl.sv - 64b/66b sync-header block lock state machine
//
// Purpose: searches for 66b block alignment by watching sync headers. In
// TEST it counts headers over a window of SH_CNT_MAX. While unlocked, any
// invalid header triggers a one-bit slip. While locked, INVLD_MAX invalid
// headers in one window drop lock. After each slip, SLIP_WAIT header beats
// are discarded so the gearbox output can settle.
//
// Ports:
//   CLK           - sole clock, rising edge
//   reset         - asynchronous active-low reset
//   hdr_valid     - sync header presented this cycle
//   sync_hdr[1:0] - sync header bits (01/10 valid, 00/11 invalid)
//   slip          - one-cycle request to shift alignment by one bit
//   block_lock    - alignment acquired
//   descr_rst     - active-high descrambler reset, always NOT block_lock
//   out_valid     - descrambler output valid on this beat
//   slip_cnt      - total slips issued, saturating at 255
//   lock_loss_cnt - total lock losses, saturating at 255
module block_lock_ctrl #(
  parameter int SH_CNT_MAX = 64,
  parameter int INVLD_MAX  = 16,
  parameter int SLIP_WAIT  = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       hdr_valid,
  input  logic [1:0] sync_hdr,
  output logic       slip,
  output logic       block_lock,
  output logic       descr_rst,
  output logic       out_valid,
  output logic [7:0] slip_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_TEST = 2'd1,
    ST_SLIP = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [6:0] SH_MAX   = 7'(SH_CNT_MAX);
  localparam logic [6:0] INV_MAX  = 7'(INVLD_MAX);
  localparam logic [3:0] WAIT_MAX = 4'(SLIP_WAIT);

  state_t     state_q, state_d;
  logic [6:0] sh_cnt_q, sh_cnt_d;
  logic [6:0] invld_cnt_q, invld_cnt_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       primed_q, primed_d;
  logic       slip_q, slip_d;
  logic       block_lock_q, block_lock_d;
  logic       descr_rst_q, descr_rst_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] slip_cnt_q, slip_cnt_d;
  logic [7:0] lock_loss_cnt_q, lock_loss_cnt_d;

  logic       hdr_bad;
  logic [6:0] sh_inc;
  logic [6:0] invld_inc;
  logic [3:0] wait_inc;

  assign hdr_bad   = (sync_hdr[1] == sync_hdr[0]);
  assign sh_inc    = sh_cnt_q + 7'd1;
  assign invld_inc = invld_cnt_q + 7'd1;
  assign wait_inc  = wait_cnt_q + 4'd1;

  always_comb begin
    state_d         = state_q;
    sh_cnt_d        = sh_cnt_q;
    invld_cnt_d     = invld_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    block_lock_d    = block_lock_q;
    slip_cnt_d      = slip_cnt_q;
    lock_loss_cnt_d = lock_loss_cnt_q;
    primed_d        = primed_q;
    out_valid_d     = 1'b0;

    case (state_q)
      ST_INIT: begin
        state_d      = ST_TEST;
        sh_cnt_d     = 7'd0;
        invld_cnt_d  = 7'd0;
        block_lock_d = 1'b0;
      end
      ST_TEST: begin
        if (hdr_valid) begin
          if (!block_lock_q) begin
            if (hdr_bad) begin
              state_d = ST_SLIP;
            end else if (sh_inc == SH_MAX) begin
              block_lock_d = 1'b1;
              sh_cnt_d     = 7'd0;
              invld_cnt_d  = 7'd0;
            end else begin
              sh_cnt_d = sh_inc;
            end
          end else begin
            // Loss of lock wins over a window that completes on the same beat.
            if (hdr_bad && (invld_inc == INV_MAX)) begin
              block_lock_d = 1'b0;
              state_d      = ST_SLIP;
              if (lock_loss_cnt_q != 8'hFF) begin
                lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
              end
            end else if (sh_inc == SH_MAX) begin
              sh_cnt_d    = 7'd0;
              invld_cnt_d = 7'd0;
            end else begin
              sh_cnt_d = sh_inc;
              if (hdr_bad) begin
                invld_cnt_d = invld_inc;
              end
            end
          end
        end
      end
      ST_SLIP: begin
        state_d    = ST_WAIT;
        wait_cnt_d = 4'd0;
      end
      ST_WAIT: begin
        if (hdr_valid) begin
          if (wait_inc == WAIT_MAX) begin
            state_d     = ST_TEST;
            wait_cnt_d  = 4'd0;
            sh_cnt_d    = 7'd0;
            invld_cnt_d = 7'd0;
          end else begin
            wait_cnt_d = wait_inc;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Outputs are registered, so they are computed from the next state.
    slip_d = (state_d == ST_SLIP);
    if (slip_d && (slip_cnt_q != 8'hFF)) begin
      slip_cnt_d = slip_cnt_q + 8'd1;
    end
    descr_rst_d = ~block_lock_d;

    // The first beat after lock primes the descrambler and is not passed on.
    if (!block_lock_d) begin
      primed_d = 1'b0;
    end else if (block_lock_q && hdr_valid) begin
      out_valid_d = primed_q;
      primed_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_INIT;
      sh_cnt_q        <= 7'd0;
      invld_cnt_q     <= 7'd0;
      wait_cnt_q      <= 4'd0;
      primed_q        <= 1'b0;
      slip_q          <= 1'b0;
      block_lock_q    <= 1'b0;
      descr_rst_q     <= 1'b1;
      out_valid_q     <= 1'b0;
      slip_cnt_q      <= 8'd0;
      lock_loss_cnt_q <= 8'd0;
    end else begin
      state_q         <= state_d;
      sh_cnt_q        <= sh_cnt_d;
      invld_cnt_q     <= invld_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      primed_q        <= primed_d;
      slip_q          <= slip_d;
      block_lock_q    <= block_lock_d;
      descr_rst_q     <= descr_rst_d;
      out_valid_q     <= out_valid_d;
      slip_cnt_q      <= slip_cnt_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
    end
  end

  assign slip          = slip_q;
  assign block_lock    = block_lock_q;
  assign descr_rst     = descr_rst_q;
  assign out_valid     = out_valid_q;
  assign slip_cnt      = slip_cnt_q;
  assign lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_block_lock_ctrl.sv
// tb/tb_block_lock_ctrl.sv - directed self-checking bench for block_lock_ctrl
module tb_block_lock_ctrl;

  logic       CLK;
  logic       reset;
  logic       hdr_valid;
  logic [1:0] sync_hdr;
  logic       slip;
  logic       block_lock;
  logic       descr_rst;
  logic       out_valid;
  logic [7:0] slip_cnt;
  logic [7:0] lock_loss_cnt;

  int total;
  int bad;

  block_lock_ctrl #(
    .SH_CNT_MAX(64),
    .INVLD_MAX (16),
    .SLIP_WAIT (4)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .hdr_valid    (hdr_valid),
    .sync_hdr     (sync_hdr),
    .slip         (slip),
    .block_lock   (block_lock),
    .descr_rst    (descr_rst),
    .out_valid    (out_valid),
    .slip_cnt     (slip_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One header beat: drive, take an edge, sample 1 time unit later.
  task automatic beat(input logic [1:0] h);
    hdr_valid = 1'b1;
    sync_hdr  = h;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    hdr_valid = 1'b0;
    sync_hdr  = 2'b00;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    total++; if (slip !== 1'b0) begin bad++; $display("FAIL %s slip got=%b exp=0", tag, slip); end
    total++; if (block_lock !== 1'b0) begin bad++; $display("FAIL %s block_lock got=%b exp=0", tag, block_lock); end
    total++; if (descr_rst !== 1'b1) begin bad++; $display("FAIL %s descr_rst got=%b exp=1", tag, descr_rst); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s out_valid got=%b exp=0", tag, out_valid); end
    total++; if (slip_cnt !== 8'd0) begin bad++; $display("FAIL %s slip_cnt got=%0d exp=0", tag, slip_cnt); end
    total++; if (lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL %s lock_loss_cnt got=%0d exp=0", tag, lock_loss_cnt); end
  endtask

  // Reset, release between edges, then one idle edge for INIT -> TEST.
  task automatic do_reset();
    hdr_valid = 1'b0;
    sync_hdr  = 2'b00;
    reset     = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    idle();
  endtask

  task automatic test_reset();
    hdr_valid = 1'b0;
    sync_hdr  = 2'b00;
    reset     = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset_state");
    @(negedge CLK);
    reset = 1'b1;
    idle();
  endtask

  task automatic test_clean_lock();
    for (int i = 0; i < 63; i++) beat(2'b01);
    total++; if (block_lock !== 1'b0) begin bad++; $display("FAIL lock_63 block_lock got=%b exp=0", block_lock); end
    beat(2'b10);
    total++; if (block_lock !== 1'b1) begin bad++; $display("FAIL lock_64 block_lock got=%b exp=1", block_lock); end
    total++; if (descr_rst !== 1'b0) begin bad++; $display("FAIL lock_64 descr_rst got=%b exp=0", descr_rst); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lock_64 out_valid got=%b exp=0", out_valid); end
    beat(2'b01);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL prime_65 out_valid got=%b exp=0", out_valid); end
    beat(2'b01);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL beat_66 out_valid got=%b exp=1", out_valid); end
    idle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gap_locked out_valid got=%b exp=0", out_valid); end
  endtask

  // Two headers of the current window are already used by test_clean_lock.
  task automatic test_tolerated();
    for (int i = 0; i < 15; i++) beat((i % 2 == 0) ? 2'b11 : 2'b00);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bad_hdr_locked out_valid got=%b exp=1", out_valid); end
    for (int i = 0; i < 47; i++) beat(2'b01);
    total++; if (block_lock !== 1'b1) begin bad++; $display("FAIL window1_15bad block_lock got=%b exp=1", block_lock); end
    // A second full window with 15 errors only survives if the window cleared.
    for (int i = 0; i < 64; i++) beat((i % 4 == 0 && i < 60) ? 2'b11 : 2'b10);
    total++; if (block_lock !== 1'b1) begin bad++; $display("FAIL window2_15bad block_lock got=%b exp=1", block_lock); end
    total++; if (lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL window2 lock_loss_cnt got=%0d exp=0", lock_loss_cnt); end
  endtask

  // 16th error lands on the 64th header: loss must win over window end.
  task automatic test_lock_loss();
    for (int i = 0; i < 48; i++) beat(2'b01);
    for (int i = 0; i < 15; i++) beat(2'b00);
    total++; if (block_lock !== 1'b1) begin bad++; $display("FAIL loss_15 block_lock got=%b exp=1", block_lock); end
    beat(2'b11);
    total++; if (block_lock !== 1'b0) begin bad++; $display("FAIL loss_16 block_lock got=%b exp=0", block_lock); end
    total++; if (lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL loss_16 lock_loss_cnt got=%0d exp=1", lock_loss_cnt); end
    total++; if (slip !== 1'b1) begin bad++; $display("FAIL loss_16 slip got=%b exp=1", slip); end
    total++; if (descr_rst !== 1'b1) begin bad++; $display("FAIL loss_16 descr_rst got=%b exp=1", descr_rst); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL loss_16 out_valid got=%b exp=0", out_valid); end
    idle();
    total++; if (slip !== 1'b0) begin bad++; $display("FAIL loss_after slip got=%b exp=0", slip); end
    total++; if (slip_cnt !== 8'd1) begin bad++; $display("FAIL loss_after slip_cnt got=%0d exp=1", slip_cnt); end
  endtask

  task automatic test_slip();
    do_reset();
    for (int i = 0; i < 9; i++) beat(2'b01);
    beat(2'b11);
    total++; if (slip !== 1'b1) begin bad++; $display("FAIL slip_pulse slip got=%b exp=1", slip); end
    total++; if (slip_cnt !== 8'd1) begin bad++; $display("FAIL slip_pulse slip_cnt got=%0d exp=1", slip_cnt); end
    idle();
    total++; if (slip !== 1'b0) begin bad++; $display("FAIL slip_end slip got=%b exp=0", slip); end
    // Invalid headers during WAIT must not cause another slip.
    for (int i = 0; i < 4; i++) begin
      beat(2'b11);
      total++; if (slip !== 1'b0) begin bad++; $display("FAIL wait_%0d slip got=%b exp=0", i, slip); end
    end
    total++; if (slip_cnt !== 8'd1) begin bad++; $display("FAIL wait_end slip_cnt got=%0d exp=1", slip_cnt); end
    for (int i = 0; i < 63; i++) beat(2'b10);
    total++; if (block_lock !== 1'b0) begin bad++; $display("FAIL relock_63 block_lock got=%b exp=0", block_lock); end
    beat(2'b10);
    total++; if (block_lock !== 1'b1) begin bad++; $display("FAIL relock_64 block_lock got=%b exp=1", block_lock); end
  endtask

  task automatic test_gapped();
    do_reset();
    for (int i = 0; i < 63; i++) begin
      beat(2'b01);
      idle();
    end
    total++; if (block_lock !== 1'b0) begin bad++; $display("FAIL gapped_63 block_lock got=%b exp=0", block_lock); end
    beat(2'b01);
    total++; if (block_lock !== 1'b1) begin bad++; $display("FAIL gapped_64 block_lock got=%b exp=1", block_lock); end
    idle();
    #3;
    reset = 1'b0;
    #1;
    total++; if (block_lock !== 1'b0) begin bad++; $display("FAIL async_locked block_lock got=%b exp=0", block_lock); end
    total++; if (descr_rst !== 1'b1) begin bad++; $display("FAIL async_locked descr_rst got=%b exp=1", descr_rst); end
  endtask

  task automatic one_slip();
    beat(2'b11);
    idle();
    for (int i = 0; i < 4; i++) beat(2'b01);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 100; i++) one_slip();
    total++; if (slip_cnt !== 8'd100) begin bad++; $display("FAIL sat_100 slip_cnt got=%0d exp=100", slip_cnt); end
    for (int i = 0; i < 200; i++) one_slip();
    total++; if (slip_cnt !== 8'd255) begin bad++; $display("FAIL sat_300 slip_cnt got=%0d exp=255", slip_cnt); end
    // Park mid-WAIT, then assert reset between clock edges.
    beat(2'b11);
    idle();
    beat(2'b01);
    beat(2'b01);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_wait");
    @(negedge CLK);
    reset = 1'b1;
    idle();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    hdr_valid = 1'b0;
    sync_hdr  = 2'b00;
    test_reset();
    test_clean_lock();
    test_tolerated();
    test_lock_loss();
    test_slip();
    test_gapped();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
